// File: rtl/id_decode_hazard_unit.sv
// ID-stage decode with a valid/ready ID/EX slot and a shift scoreboard of in-flight writes that interlocks on RAW hazards.
// Optional build macro FWD_EN: interlock only on load-use and report forwarding selects instead.
module id_decode_hazard_unit #(
  parameter int                INSTR_W    = 20,
  parameter int                OPC_W      = 4,
  parameter int                REG_AW     = 4,
  parameter int                PIPE_DEPTH = 3,
  parameter logic [OPC_W-1:0]  STORE_OPC  = 4'b1100,
  parameter logic [OPC_W-1:0]  NOP_OPC    = 4'b0000,
  parameter logic [OPC_W-1:0]  LOAD_OPC   = 4'b1011
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic               out_we,
  output logic [REG_AW-1:0]  out_waddr,
  output logic [REG_AW-1:0]  out_raddr1,
  output logic [REG_AW-1:0]  out_raddr2,
  output logic               stall,
  output logic [1:0]         fwd_sel1,
  output logic [1:0]         fwd_sel2
);

  localparam int F0_HI = INSTR_W - OPC_W - 1;
  localparam int F1_HI = F0_HI - REG_AW;
  localparam int F2_HI = F1_HI - REG_AW;

  // Decode
  logic [OPC_W-1:0]  w_opc;
  logic [REG_AW-1:0] w_f0, w_f1, w_f2;
  logic              w_is_nop;
  logic              w_we;
  logic [REG_AW-1:0] w_waddr, w_raddr1, w_raddr2;

  assign w_opc    = instruction[INSTR_W-1 -: OPC_W];
  assign w_f0     = instruction[F0_HI -: REG_AW];
  assign w_f1     = instruction[F1_HI -: REG_AW];
  assign w_f2     = instruction[F2_HI -: REG_AW];
  assign w_is_nop = (w_opc == NOP_OPC);

  always_comb begin
    w_we     = 1'b0;
    w_waddr  = '0;
    w_raddr1 = '0;
    w_raddr2 = '0;
    if (w_opc == STORE_OPC) begin
      w_raddr1 = w_f0;
      w_raddr2 = w_f1;
    end else if (!w_is_nop) begin
      w_we     = 1'b1;
      w_waddr  = w_f0;
      w_raddr1 = w_f1;
      w_raddr2 = w_f2;
    end
  end

  // ID/EX slot and scoreboard state
  logic              r_valid;
  logic [OPC_W-1:0]  r_opc;
  logic              r_we;
  logic [REG_AW-1:0] r_waddr, r_raddr1, r_raddr2;

  logic [PIPE_DEPTH-1:0] r_sb_vld;
  logic [REG_AW-1:0]     r_sb_waddr [PIPE_DEPTH];

  logic w_accept, w_issue, w_hazard, w_in_act;
  logic w_sb_push;

  assign w_issue   = r_valid && out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_in_act  = in_valid && !w_is_nop;
  // A flushed instruction never reaches EX, so it must not occupy the scoreboard
  assign w_sb_push = w_issue && !flush && r_we;

  // Per-source match against every scoreboard entry and against the held slot
  logic [PIPE_DEPTH-1:0] w_m1_sb, w_m2_sb;
  logic                  w_m1_slot, w_m2_slot;

  always_comb begin
    w_m1_sb = '0;
    w_m2_sb = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      w_m1_sb[i] = r_sb_vld[i] && (r_sb_waddr[i] == w_raddr1);
      w_m2_sb[i] = r_sb_vld[i] && (r_sb_waddr[i] == w_raddr2);
    end
    w_m1_slot = r_valid && r_we && (r_waddr == w_raddr1);
    w_m2_slot = r_valid && r_we && (r_waddr == w_raddr2);
  end

`ifdef FWD_EN
  logic [PIPE_DEPTH-1:0] r_sb_load;
  logic                  w_slot_load;
  logic                  w_lu1, w_lu2;

  // Youngest producer wins; the held slot is about to enter EX, so it selects the EX path
  function automatic logic [1:0] fwd_pick(input logic [PIPE_DEPTH-1:0] m, input logic slot);
    logic [1:0] sel;
    sel = 2'd0;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      if (m[i]) sel = (i == 0) ? 2'd1 : ((i == 1) ? 2'd2 : 2'd3);
    end
    if (slot) sel = 2'd1;
    return sel;
  endfunction

  assign w_slot_load = r_valid && r_we && (r_opc == LOAD_OPC);
  assign w_lu1       = (w_m1_sb[0] && r_sb_load[0]) || (w_m1_slot && w_slot_load);
  assign w_lu2       = (w_m2_sb[0] && r_sb_load[0]) || (w_m2_slot && w_slot_load);
  assign w_hazard    = w_in_act && (w_lu1 || w_lu2);
  assign fwd_sel1    = w_in_act ? fwd_pick(w_m1_sb, w_m1_slot) : 2'd0;
  assign fwd_sel2    = w_in_act ? fwd_pick(w_m2_sb, w_m2_slot) : 2'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sb_load <= '0;
    end else begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) r_sb_load[i] <= r_sb_load[i-1];
      r_sb_load[0] <= w_sb_push && (r_opc == LOAD_OPC);
    end
  end
`else
  // Loads are ordinary writers under full interlock
  logic w_unused_load_opc;
  assign w_unused_load_opc = ^LOAD_OPC;

  assign w_hazard = w_in_act && ((|w_m1_sb) || w_m1_slot || (|w_m2_sb) || w_m2_slot);
  assign fwd_sel1 = 2'd0;
  assign fwd_sel2 = 2'd0;
`endif

  assign in_ready = reset && !w_hazard && !flush && (!r_valid || out_ready);
  assign stall    = in_valid && !in_ready;

  // ID/EX slot register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_opc    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_raddr1 <= '0;
      r_raddr2 <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_opc    <= w_opc;
      r_we     <= w_we;
      r_waddr  <= w_waddr;
      r_raddr1 <= w_raddr1;
      r_raddr2 <= w_raddr2;
    end else if (w_issue) begin
      r_valid <= 1'b0;
    end
  end

  // Scoreboard: EX onward never stalls, so entries advance every cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sb_vld <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) r_sb_waddr[i] <= '0;
    end else begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
        r_sb_vld[i]   <= r_sb_vld[i-1];
        r_sb_waddr[i] <= r_sb_waddr[i-1];
      end
      r_sb_vld[0]   <= w_sb_push;
      r_sb_waddr[0] <= r_waddr;
    end
  end

  assign out_valid  = r_valid;
  assign out_opcode = r_opc;
  assign out_we     = r_we;
  assign out_waddr  = r_waddr;
  assign out_raddr1 = r_raddr1;
  assign out_raddr2 = r_raddr2;

endmodule

// File: tb/tb_id_decode_hazard_unit.sv
// Scoreboard bench for id_decode_hazard_unit (default build, full interlock, PIPE_DEPTH=3).
module tb_id_decode_hazard_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] instruction;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [3:0]  out_opcode, out_waddr, out_raddr1, out_raddr2;
  logic        out_we, stall;
  logic [1:0]  fwd_sel1, fwd_sel2;

  id_decode_hazard_unit dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_we(out_we), .out_waddr(out_waddr), .out_raddr1(out_raddr1),
    .out_raddr2(out_raddr2), .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] opc;
    logic       we;
    logic       nop;
    logic [3:0] wa;
    logic [3:0] r1;
    logic [3:0] r2;
  } dec_t;

  dec_t       q[$];
  logic       m_vld [3];
  logic [3:0] m_wa  [3];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       last_stall, last_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 4'h0};
  endfunction

  function automatic dec_t dec(input logic [19:0] ins);
    dec_t d;
    d = '0;
    d.opc = ins[19:16];
    if (d.opc == 4'h0) d.nop = 1'b1;
    else if (d.opc == 4'hC) begin
      d.r1 = ins[15:12];
      d.r2 = ins[11:8];
    end else begin
      d.we = 1'b1;
      d.wa = ins[15:12];
      d.r1 = ins[11:8];
      d.r2 = ins[7:4];
    end
    return d;
  endfunction

  function automatic logic m_match(input logic [3:0] a);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3; i++) if (m_vld[i] && m_wa[i] == a) hit = 1'b1;
    if (q.size() > 0 && q[0].we && q[0].wa == a) hit = 1'b1;
    return hit;
  endfunction

  // One clock: check at the falling edge, advance the model, return 1ns after the rising edge
  task automatic cycle();
    dec_t d, e;
    logic haz, exp_rdy, issue, acc, nv;
    logic [3:0] na;
    @(negedge clock);
    last_stall = stall;
    last_rdy   = in_ready;
    if (!reset) begin
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_we", out_we, 1'b0);
      check("rst_fields", {out_opcode, out_waddr, out_raddr1, out_raddr2}, 16'h0);
      q.delete();
      for (int i = 0; i < 3; i++) begin m_vld[i] = 1'b0; m_wa[i] = 4'h0; end
    end else begin
      d   = dec(instruction);
      haz = in_valid && !d.nop && (m_match(d.r1) || m_match(d.r2));
      exp_rdy = !haz && !flush && ((q.size() == 0) || out_ready);
      check("in_ready", in_ready, exp_rdy);
      check("stall", stall, in_valid && !exp_rdy);
      check("out_valid", out_valid, q.size() > 0);
      check("fwd_sel", {fwd_sel1, fwd_sel2}, 4'h0);
      if (q.size() > 0) begin
        e = q[0];
        check("out_opcode", out_opcode, e.opc);
        check("out_we", out_we, e.we);
        if (e.we) check("out_waddr", out_waddr, e.wa);
        if (!e.nop) check("out_raddr", {out_raddr1, out_raddr2}, {e.r1, e.r2});
      end
      issue = (q.size() > 0) && out_ready;
      acc   = in_valid && exp_rdy;
      nv    = issue && !flush && q[0].we;
      na    = (q.size() > 0) ? q[0].wa : 4'h0;
      m_vld[2] = m_vld[1]; m_wa[2] = m_wa[1];
      m_vld[1] = m_vld[0]; m_wa[1] = m_wa[0];
      m_vld[0] = nv;       m_wa[0] = na;
      if (flush) begin
        if (q.size() > 0) void'(q.pop_front());
      end else begin
        if (issue) void'(q.pop_front());
        if (acc) q.push_back(d);
      end
    end
    @(posedge clock);
    #1;
  endtask

  int         cnt;
  logic [3:0] snap_wa, snap_r1, snap_op;

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instruction = '0;
    for (int i = 0; i < 3; i++) begin m_vld[i] = 1'b0; m_wa[i] = 4'h0; end
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    check("ready_after_reset", in_ready, 1'b1);

    // Independent back-to-back adds
    in_valid = 1'b1; instruction = mk(4'h1, 4'd1, 4'd2, 4'd3);
    cycle();
    check("b2b_valid0", out_valid, 1'b1);
    check("b2b_waddr0", out_waddr, 4'd1);
    instruction = mk(4'h1, 4'd4, 4'd5, 4'd6);
    cycle();
    check("b2b_no_stall", last_stall, 1'b0);
    check("b2b_waddr1", out_waddr, 4'd4);
    in_valid = 1'b0;
    repeat (5) cycle();

    // RAW: ADD r1 then SUB r2,r1,r3
    in_valid = 1'b1; instruction = mk(4'h1, 4'd1, 4'd2, 4'd3);
    cycle();
    instruction = mk(4'h2, 4'd2, 4'd1, 4'd3);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (!last_stall) break;
      cnt++;
    end
    check("raw_stall_cycles", cnt, 4);
    check("raw_sub_valid", out_valid, 1'b1);
    check("raw_sub_raddr1", out_raddr1, 4'd1);
    in_valid = 1'b0;
    repeat (5) cycle();

    // Store layout, then a reader of the stored register
    in_valid = 1'b1; instruction = mk(4'hC, 4'd5, 4'd6, 4'hA);
    cycle();
    check("store_we", out_we, 1'b0);
    check("store_raddr1", out_raddr1, 4'd5);
    check("store_raddr2", out_raddr2, 4'd6);
    instruction = mk(4'h1, 4'd7, 4'd5, 4'd0);
    cycle();
    check("store_no_stall", last_stall, 1'b0);
    in_valid = 1'b0;
    repeat (5) cycle();

    // Hold with back-pressure, flush on the third cycle
    out_ready = 1'b0; in_valid = 1'b1; instruction = mk(4'h1, 4'd7, 4'd8, 4'd9);
    cycle();
    snap_wa = out_waddr; snap_r1 = out_raddr1; snap_op = out_opcode;
    instruction = mk(4'h1, 4'd10, 4'd11, 4'd12);
    for (int c = 1; c <= 5; c++) begin
      flush = (c == 3);
      cycle();
      flush = 1'b0;
      if (c <= 3) check("hold_in_ready", last_rdy, 1'b0);
      if (c < 3) check("hold_stable", {out_valid, out_opcode, out_waddr, out_raddr1},
                       {1'b1, snap_op, snap_wa, snap_r1});
      if (c == 3) check("flush_out_valid", out_valid, 1'b0);
    end
    out_ready = 1'b1; instruction = mk(4'h2, 4'd13, 4'd7, 4'd8);
    cycle();
    check("flush_sb_no_r7", last_stall, 1'b0);
    in_valid = 1'b0;
    repeat (5) cycle();

    // Mid-stream reset with slot full and scoreboard busy
    in_valid = 1'b1; instruction = mk(4'h1, 4'd2, 4'd3, 4'd4);
    cycle();
    instruction = mk(4'h1, 4'd3, 4'd4, 4'd5);
    cycle();
    out_ready = 1'b0; in_valid = 1'b0;
    cycle();
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    cycle();
    reset = 1'b1; out_ready = 1'b1;
    cycle();
    check("midrst_ready_after", last_rdy, 1'b1);
    in_valid = 1'b1; instruction = mk(4'h1, 4'd6, 4'd2, 4'd3);
    cycle();
    check("midrst_sb_clear", last_stall, 1'b0);
    in_valid = 1'b0;
    repeat (5) cycle();

    // Random traffic with hazards, back-pressure and flushes
    for (int k = 0; k < 400; k++) begin
      logic [3:0] ops [4];
      ops[0] = 4'h1; ops[1] = 4'h2; ops[2] = 4'hC; ops[3] = 4'h0;
      in_valid    = ($urandom_range(3) != 0);
      instruction = mk(ops[$urandom_range(3)], 4'($urandom_range(7)),
                       4'($urandom_range(7)), 4'($urandom_range(7)));
      out_ready   = ($urandom_range(3) != 0);
      flush       = ($urandom_range(15) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
